// File: rtl/brisc_alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the BRISC execute unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package brisc_alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOT   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_MUL   = 4'd9;
    localparam logic [3:0] ALU_CMP   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/brisc_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: WIDTH cycles after start; done marks the edge that completes the product.
// Backpressure: start is ignored while an operation is running.
module brisc_shift_add_mul
    import brisc_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               running;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // product is the accumulator after the current iteration; valid as the final
    // answer on the edge where done is high, letting the caller register it there.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start && !running) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/brisc_seq_alu.sv
// Registered execute unit: single-cycle ALU ops plus an iterative MUL with start/busy/done.
// Latency: 1 cycle for non-MUL ops, WIDTH cycles for MUL.
// Backpressure: busy high during MUL; start is dropped (not queued) while busy.
module brisc_seq_alu
    import brisc_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t             state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   done_q, done_d;

    logic                   mul_start, mul_done;
    logic [2*WIDTH-1:0]     product;

    logic [SHW-1:0]         sh;
    logic [WIDTH:0]         sum, diff, shl_ext, shr_ext;
    logic signed [WIDTH:0]  sra_ext;
    logic                   v_add, v_sub;
    logic [WIDTH-1:0]       val;
    logic                   c_bit, v_bit, upd, wr;

    // Shifts carry one extra bit so the last bit shifted out lands in a fixed
    // position; a zero shift leaves that bit at 0.
    assign sh      = b[SHW-1:0];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;
    assign v_add   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign v_sub   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    brisc_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        val       = '0;
        c_bit     = 1'b0;
        v_bit     = 1'b0;
        upd       = 1'b0;
        wr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    upd    = 1'b1;
                    wr     = 1'b1;
                    case (op)
                        ALU_ADD:   begin val = sum[WIDTH-1:0]; c_bit = sum[WIDTH]; v_bit = v_add; end
                        ALU_SUB,
                        ALU_CMP:   begin
                            val   = diff[WIDTH-1:0];
                            c_bit = diff[WIDTH];
                            v_bit = v_sub;
                            wr    = (op == ALU_SUB);
                        end
                        ALU_AND:   val = a & b;
                        ALU_OR:    val = a | b;
                        ALU_XOR:   val = a ^ b;
                        ALU_NOT:   val = ~a;
                        ALU_SHL:   begin val = shl_ext[WIDTH-1:0]; c_bit = shl_ext[WIDTH]; end
                        ALU_SHR:   begin val = shr_ext[WIDTH:1];   c_bit = shr_ext[0]; end
                        ALU_SRA:   begin val = sra_ext[WIDTH:1];   c_bit = sra_ext[0]; end
                        ALU_PASSB: val = b;
                        ALU_MUL:   begin
                            mul_start = 1'b1;
                            done_d    = 1'b0;
                            upd       = 1'b0;
                            wr        = 1'b0;
                            state_d   = ST_MUL;
                        end
                        default:   begin upd = 1'b0; wr = 1'b0; end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    val     = product[WIDTH-1:0];
                    c_bit   = |product[2*WIDTH-1:WIDTH];
                    upd     = 1'b1;
                    wr      = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (upd) begin
            flags_d[FLAG_Z] = (val == '0);
            flags_d[FLAG_N] = val[WIDTH-1];
            flags_d[FLAG_C] = c_bit;
            flags_d[FLAG_V] = v_bit;
            if (wr) begin
                result_d = val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign flag_z = flags_q[FLAG_Z];
    assign flag_n = flags_q[FLAG_N];
    assign flag_c = flags_q[FLAG_C];
    assign flag_v = flags_q[FLAG_V];
    assign busy   = (state_q == ST_MUL);
    assign done   = done_q;

endmodule

// File: tb/tb_brisc_seq_alu.sv
// Randomized and directed bench for brisc_seq_alu against an arithmetic reference model.
module tb_brisc_seq_alu;
    import brisc_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] result;
    logic        flag_z, flag_n, flag_c, flag_v, busy, done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_res;
    logic [3:0]  exp_flg;   // {V, C, N, Z}

    always #5 clk = ~clk;

    brisc_seq_alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference behaviour from plain integer arithmetic.
    task automatic ref_model(input int op_i, input int a_i, input int b_i);
        int r, sh, s;
        bit c, v, upd;
        longint p;
        c = 0; v = 0; upd = 1; sh = b_i & 15; r = int'(exp_res);
        case (op_i)
            0:  begin r = a_i + b_i; c = (r > 65535); s = sx(a_i) + sx(b_i); v = (s > 32767) || (s < -32768); end
            1, 10: begin r = a_i - b_i; c = (a_i < b_i); s = sx(a_i) - sx(b_i); v = (s > 32767) || (s < -32768); end
            2:  r = a_i & b_i;
            3:  r = a_i | b_i;
            4:  r = a_i ^ b_i;
            5:  r = ~a_i;
            6:  begin r = a_i << sh; c = (sh != 0) ? 1'((a_i >> (16 - sh)) & 1) : 1'b0; end
            7:  begin r = a_i >> sh; c = (sh != 0) ? 1'((a_i >> (sh - 1)) & 1) : 1'b0; end
            8:  begin r = sx(a_i) >>> sh; c = (sh != 0) ? 1'((a_i >> (sh - 1)) & 1) : 1'b0; end
            9:  begin p = longint'(a_i) * longint'(b_i); r = int'(p & 64'hFFFF); c = ((p >> 16) != 0); end
            11: r = b_i;
            default: upd = 0;
        endcase
        if (upd) begin
            exp_flg = {v, c, 1'((r >> 15) & 1), ((r & 16'hFFFF) == 0)};
            if (op_i != 10) exp_res = 16'(r);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flags"}, 32'({flag_v, flag_c, flag_n, flag_z}), 32'(exp_flg));
    endtask

    // Entered just after a falling edge; returns at the falling edge where done is expected.
    task automatic run_op(input logic [3:0] op_i, input logic [15:0] a_i, input logic [15:0] b_i);
        int n;
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        ref_model(int'(op_i), int'(a_i), int'(b_i));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (op_i == ALU_MUL) begin
            n = 0;
            while (busy && n < 40) begin
                a = 16'($urandom); b = 16'($urandom); op = 4'($urandom_range(0, 15));
                check("mul_done_while_busy", 32'(done), 32'd0);
                n++;
                @(negedge clk);
            end
            check("mul_busy_cycles", 32'(n), 32'd16);
        end
        check("op_done", 32'(done), 32'd1);
        check("op_busy_low", 32'(busy), 32'd0);
        check_outputs($sformatf("op%0d", op_i));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        exp_res = '0; exp_flg = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(ALU_ADD, 16'h7FFF, 16'h0001);
        check("add_ovf_result", 32'(result), 32'h8000);
        check("add_ovf_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'b1010);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);

        run_op(ALU_SUB, 16'h0003, 16'h0005);
        check("sub_result", 32'(result), 32'hFFFE);
        run_op(ALU_CMP, 16'h1234, 16'h1234);
        check("cmp_keeps_result", 32'(result), 32'hFFFE);
        check("cmp_z", 32'(flag_z), 32'd1);
        run_op(ALU_SHL, 16'h8001, 16'h0001);
        check("shl_c", 32'(flag_c), 32'd1);
        run_op(ALU_SRA, 16'h8000, 16'h0004);
        check("sra_result", 32'(result), 32'hF800);
        run_op(ALU_SHL, 16'hA5A5, 16'h0000);
        check("shl0_c", 32'(flag_c), 32'd0);
        run_op(ALU_NOT, 16'h00FF, 16'h0000);
        run_op(4'd13, 16'h1111, 16'h2222);
        run_op(ALU_MUL, 16'h1000, 16'h0010);
        check("mul_wrap_zc", 32'({flag_c, flag_z}), 32'b11);

        // MUL with a stray ADD pulsed mid-iteration, then an ADD in the done cycle.
        start = 1'b1; op = ALU_MUL; a = 16'h0123; b = 16'h0045;
        ref_model(int'(ALU_MUL), 'h0123, 'h0045);
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!done && n < 40) begin
            if (n == 4) begin
                start = 1'b1; op = ALU_ADD; a = 16'h0001; b = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("ign_latency", 32'(n), 32'd16);
        check("ign_mul_result", 32'(result), 32'h4E6F);
        check_outputs("ign_mul");
        run_op(ALU_ADD, 16'h1000, 16'h0234);
        check("add_in_done_cycle", 32'(result), 32'h1234);

        // Reset during MUL iteration 8 aborts without a done.
        @(negedge clk);
        start = 1'b1; op = ALU_MUL; a = 16'h00FF; b = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_res = '0; exp_flg = '0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("abort_quiet", 32'(n), 32'd0);
        run_op(ALU_ADD, 16'h0002, 16'h0003);
        check("add_after_abort", 32'(result), 32'h0005);

        // Random mix, back-to-back with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = rb;
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                check("idle_done", 32'(done), 32'd0);
            end
            run_op(4'($urandom_range(0, 15)), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/brisc_seq_alu.md
# brisc_seq_alu

Registered 16-bit execute unit for the BRISC core. It sits directly downstream of the immediate/register operand select and consumes its 16-bit output as operand B. Operand A comes from the register file. Most ops complete in one cycle; MUL is iterative shift-add over 16 cycles. Completion is signalled with a `start`/`busy`/`done` handshake that the control unit uses to stall.

## Interface
Parameters:
- `WIDTH`, default 16: datapath width. MUL iteration count equals `WIDTH`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 4: opcode, encoded per the shared package.
- `a` input WIDTH: operand A, from the register file.
- `b` input WIDTH: operand B, from the operand mux (`data_to_alu`).
- `result` output WIDTH: registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` output 1 each: registered flags.
- `busy` output 1: high while a MUL iterates.
- `done` output 1: one-cycle pulse marking `result`/flags as updated.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a).
  - 6 SHL, 7 SHR (logical), 8 SRA.
  - 9 MUL, 10 CMP, 11 PASSB (result=b).
  - 12–15 NOP.
- Shift amount is `b[3:0]`. A shift by 0 leaves `a` unchanged and sets C=0.
- Flags:
  - Z = (new result == 0); N = new result[15].
  - C for ADD: carry-out.
  - C for SUB/CMP: borrow, i.e. 1 iff a<b unsigned.
  - C for shifts: the last bit shifted out.
  - C for MUL: 1 iff product bits [31:16] are nonzero.
  - C for logic ops and PASSB: 0.
  - V: signed overflow for ADD/SUB/CMP; 0 for all other ops.
- CMP computes a−b and updates all four flags. `result` holds its previous value; Z/N derive from the difference.
- NOP: `result` and flags unchanged, `done` still pulses.
- MUL: unsigned shift-add with 2·WIDTH accumulator. `result` = low WIDTH bits.
- Operands `a`, `b` and `op` are captured at accept. Later changes have no effect on an in-flight MUL.
- FSM states:
  - IDLE → IDLE on `start` with a non-MUL op; the result is registered and `done` pulses.
  - IDLE → MUL on `start` with op=MUL.
  - MUL → IDLE after WIDTH iterations; result written, `done` pulses.
- `start` while `busy`=1 is ignored, with no queuing.
- Reset values: `result`=0, all flags 0, `busy`=0, `done`=0, FSM=IDLE, iteration counter=0.
- `rst_n` low mid-MUL aborts the operation. Outputs go to their reset values at that edge, and no `done` is issued for the aborted op.

## Timing
- Accept edge E0 = first rising edge with `start`=1, `busy`=0, `rst_n`=1.
- Non-MUL ops:
  - `result`/flags update at E0.
  - `done`=1 for exactly the cycle after E0.
  - Latency is 1.
- MUL:
  - `busy` rises at E0; iterations run on edges E1..E16.
  - At E16: `result`/flags update, `busy` falls, and `done`=1 for the following cycle.
  - Latency is WIDTH.
- Back-to-back ops are allowed. `start` sampled while `done`=1 and `busy`=0 is accepted, giving a throughput of one non-MUL op per cycle.
- `done` and `busy` are never high in the same cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `brisc_alu_pkg` holds:
  - the opcode localparams (`ALU_ADD`..`ALU_PASSB`);
  - the FSM state encoding;
  - flag bit indices.
- The decoder and control unit import the same package.
- One sub-module: `brisc_shift_add_mul`. It contains the iterative multiplier, the counter, the accumulator, and its own `start`/`done` signals. The top level holds the single-cycle datapath, the flag logic and the FSM.

## Test plan
- Reset, then ADD a=0x7FFF, b=0x0001 → next cycle `result`=0x8000, N=1, V=1, C=0, Z=0, `done` pulse of width 1.
- SUB a=0x0003, b=0x0005 → 0xFFFE, C=1, N=1, V=0. CMP with a=b=0x1234 → Z=1, `result` unchanged.
- SHL a=0x8001, b=1 → 0x0002, C=1. SRA a=0x8000, b=4 → 0xF800. SHL with b=0 → unchanged, C=0.
- MUL 0x0123×0x0045:
  - `busy` high for 16 cycles, then `result`=0x4E6F, C=0, `done` pulse.
  - MUL 0x1000×0x0010 → 0x0000, Z=1, C=1.
- `start`/ADD pulsed during MUL iteration 5 is ignored: MUL result intact and exactly one `done`. ADD issued in the `done` cycle completes one cycle later.
- `rst_n` low for one cycle at MUL iteration 8 → `busy`=0, `result`=0, flags 0, no `done`. A following ADD 2+3 → 0x0005 with normal latency.
